// File: rtl/ub_fifo_dma_if.sv
// Bundles the DMA command, RX/TX FIFO and unified_buffer byte-port signals of ub_fifo_dma.
// master = the DMA engine, slave = the surrounding host/FIFO/buffer side.
interface ub_fifo_dma_if #(
  parameter int BUFFER_SIZE     = 1024,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int ADDRESS_SIZE    = $clog2(BUFFER_SIZE)
);
  // command side
  logic                       start;
  logic                       dir;
  logic [ADDRESS_SIZE-1:0]    base_addr;
  logic [ADDRESS_SIZE:0]      word_count;
  logic                       busy;
  logic                       done;
  // RX FIFO (first-word-fall-through)
  logic                       rx_empty;
  logic [FIFO_DATA_WIDTH-1:0] rx_data;
  logic                       rx_rd_en;
  // TX FIFO
  logic                       tx_full;
  logic                       tx_wr_en;
  logic [FIFO_DATA_WIDTH-1:0] tx_data;
  // unified_buffer byte port
  logic                       ub_we;
  logic                       ub_re;
  logic                       ub_fifo_en;
  logic                       ub_compute_en;
  logic                       ub_section;
  logic [ADDRESS_SIZE-1:0]    ub_address;
  logic [FIFO_DATA_WIDTH-1:0] ub_fifo_in;
  logic [FIFO_DATA_WIDTH-1:0] ub_fifo_out;
  logic                       ub_done;

  modport master (
    input  start, dir, base_addr, word_count,
    input  rx_empty, rx_data, tx_full, ub_fifo_out, ub_done,
    output busy, done, rx_rd_en, tx_wr_en, tx_data,
    output ub_we, ub_re, ub_fifo_en, ub_compute_en, ub_section, ub_address, ub_fifo_in
  );

  modport slave (
    output start, dir, base_addr, word_count,
    output rx_empty, rx_data, tx_full, ub_fifo_out, ub_done,
    input  busy, done, rx_rd_en, tx_wr_en, tx_data,
    input  ub_we, ub_re, ub_fifo_en, ub_compute_en, ub_section, ub_address, ub_fifo_in
  );
endinterface

// File: rtl/ub_fifo_dma.sv
// Byte-port DMA for unified_buffer: loads RX FIFO bytes into buffer words or stores words to the TX FIFO, low byte first.
// 3 cycles per byte plus one FIN cycle; stalls on rx_empty, tx_full and ub_done, start ignored while busy.
module ub_fifo_dma #(
  parameter int BUFFER_SIZE     = 1024,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int ADDRESS_SIZE    = $clog2(BUFFER_SIZE)
) (
  input logic           clk,
  input logic           rst,
  ub_fifo_dma_if.master bus
);

  localparam logic [ADDRESS_SIZE-1:0] ADDR_LAST = ADDRESS_SIZE'(BUFFER_SIZE - 1);
  localparam logic [ADDRESS_SIZE-1:0] ADDR_ONE  = ADDRESS_SIZE'(1);
  localparam logic [ADDRESS_SIZE:0]   CNT_ONE   = (ADDRESS_SIZE + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_WAIT,
    S_LD_WR,
    S_LD_ACK,
    S_ST_RD,
    S_ST_ACK,
    S_ST_PUSH,
    S_FIN
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDRESS_SIZE-1:0]    addr_q, addr_d;
  logic                       sec_q, sec_d;
  logic [ADDRESS_SIZE:0]      cnt_q, cnt_d;
  logic [FIFO_DATA_WIDTH-1:0] wr_byte_q, wr_byte_d;
  logic [FIFO_DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;

  logic                       sec_adv;
  logic [ADDRESS_SIZE-1:0]    addr_adv;
  logic [ADDRESS_SIZE:0]      cnt_adv;
  logic                       last_byte;
  logic                       we, re;

  // Position after the current byte: high byte completes the word and moves to the next address.
  always_comb begin
    sec_adv   = ~sec_q;
    addr_adv  = addr_q;
    cnt_adv   = cnt_q;
    last_byte = sec_q && (cnt_q == CNT_ONE);
    if (sec_q) begin
      addr_adv = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;
      cnt_adv  = cnt_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sec_d     = sec_q;
    cnt_d     = cnt_q;
    wr_byte_d = wr_byte_q;
    tx_byte_d = tx_byte_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d = bus.base_addr;
          cnt_d  = bus.word_count;
          sec_d  = 1'b0;
          if (bus.word_count == '0) begin
            state_d = S_FIN;
          end else if (bus.dir) begin
            state_d = S_ST_RD;
          end else begin
            state_d = S_LD_WAIT;
          end
        end
      end
      S_LD_WAIT: begin
        if (!bus.rx_empty) begin
          wr_byte_d = bus.rx_data;
          state_d   = S_LD_WR;
        end
      end
      S_LD_WR: begin
        state_d = S_LD_ACK;
      end
      S_LD_ACK: begin
        if (bus.ub_done) begin
          sec_d   = sec_adv;
          addr_d  = addr_adv;
          cnt_d   = cnt_adv;
          state_d = last_byte ? S_FIN : S_LD_WAIT;
        end
      end
      S_ST_RD: begin
        state_d = S_ST_ACK;
      end
      S_ST_ACK: begin
        if (bus.ub_done) begin
          tx_byte_d = bus.ub_fifo_out;
          state_d   = S_ST_PUSH;
        end
      end
      S_ST_PUSH: begin
        if (!bus.tx_full) begin
          sec_d   = sec_adv;
          addr_d  = addr_adv;
          cnt_d   = cnt_adv;
          state_d = last_byte ? S_FIN : S_ST_RD;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      sec_q     <= 1'b0;
      cnt_q     <= '0;
      wr_byte_q <= '0;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sec_q     <= sec_d;
      cnt_q     <= cnt_d;
      wr_byte_q <= wr_byte_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Strobes are suppressed during reset so an abort never pops, pushes or touches the buffer.
  assign we = !rst && (state_q == S_LD_WR);
  assign re = !rst && (state_q == S_ST_RD);

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = !rst && (state_q == S_FIN);
  assign bus.rx_rd_en      = !rst && (state_q == S_LD_WAIT) && !bus.rx_empty;
  assign bus.tx_wr_en      = !rst && (state_q == S_ST_PUSH) && !bus.tx_full;
  assign bus.tx_data       = tx_byte_q;
  assign bus.ub_we         = we;
  assign bus.ub_re         = re;
  assign bus.ub_fifo_en    = we | re;
  assign bus.ub_compute_en = 1'b0;
  assign bus.ub_section    = sec_q;
  assign bus.ub_address    = addr_q;
  assign bus.ub_fifo_in    = wr_byte_q;

  a_we_re_exclusive: assert property (@(posedge clk) disable iff (rst) !(we && re));
  a_strobe_single:   assert property (@(posedge clk) disable iff (rst) (we || re) |=> !(we || re));

endmodule

// File: tb/tb_ub_fifo_dma.sv
// Randomized bench for ub_fifo_dma with a word-level buffer/FIFO environment and reference expectations.
module tb_ub_fifo_dma;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ub_fifo_dma_if bus ();
  ub_fifo_dma dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mem     [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  stim_q[$];
  logic [7:0]  exp_tx[$];

  int pop_cnt, we_cnt, re_cnt, push_cnt, done_cnt, viol;
  bit rx_toggle, rand_gaps;
  int stall_at, stall_left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tx_at(input int i);
    return (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hDEAD;
  endfunction

  // Environment: unified buffer (ack one cycle after a strobe), RX FIFO source, TX FIFO sink.
  initial begin : env
    logic s_we, s_re, s_sec, s_pop, s_push, s_done, s_full, s_empty, s_fen, s_ubd;
    logic [9:0] s_addr;
    logic [7:0] s_in, s_txd, p_txd;
    logic p_full, p_ubd;
    bit gap, rx_phase;
    p_full = 0; p_ubd = 0; p_txd = 0; rx_phase = 0;
    bus.rx_empty = 1'b1; bus.rx_data = '0; bus.tx_full = 1'b0;
    bus.ub_fifo_out = '0; bus.ub_done = 1'b0;
    forever begin
      @(negedge clk);
      s_we = bus.ub_we; s_re = bus.ub_re; s_sec = bus.ub_section; s_addr = bus.ub_address;
      s_in = bus.ub_fifo_in; s_pop = bus.rx_rd_en; s_push = bus.tx_wr_en; s_txd = bus.tx_data;
      s_done = bus.done; s_full = bus.tx_full; s_empty = bus.rx_empty; s_fen = bus.ub_fifo_en;
      s_ubd = bus.ub_done;
      if (s_we && s_re) viol++;
      if ((s_we || s_re) && !s_fen) viol++;
      if (s_push && s_full) viol++;
      if (s_pop && s_empty) viol++;
      if (s_we && we_cnt >= pop_cnt) viol++;
      if (bus.ub_compute_en) viol++;
      if (s_full && p_full && !p_ubd && s_txd != p_txd) viol++;
      p_full = s_full; p_ubd = s_ubd; p_txd = s_txd;
      @(posedge clk); #1;
      if (s_pop && rx_q.size() > 0) begin
        void'(rx_q.pop_front());
        pop_cnt++;
      end
      if (s_we) begin
        if (s_sec) mem[s_addr][15:8] = s_in;
        else       mem[s_addr][7:0]  = s_in;
        we_cnt++;
      end
      if (s_re) begin
        bus.ub_fifo_out = s_sec ? mem[s_addr][15:8] : mem[s_addr][7:0];
        re_cnt++;
      end
      bus.ub_done = s_we || s_re;
      if (s_push) begin
        tx_q.push_back(s_txd);
        push_cnt++;
      end
      if (s_done) done_cnt++;
      if (stall_left > 0 && push_cnt == stall_at) begin
        bus.tx_full = 1'b1;
        stall_left--;
      end else begin
        bus.tx_full = rand_gaps && ($urandom_range(0, 3) == 0);
      end
      rx_phase = ~rx_phase;
      gap = rx_toggle ? rx_phase : (rand_gaps && ($urandom_range(0, 2) == 0));
      bus.rx_empty = (rx_q.size() == 0) || gap;
      bus.rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  task automatic check_idle_zero(input string pfx);
    chk({pfx, "_busy"},       32'(bus.busy), 0);
    chk({pfx, "_done"},       32'(bus.done), 0);
    chk({pfx, "_rx_rd_en"},   32'(bus.rx_rd_en), 0);
    chk({pfx, "_tx_wr_en"},   32'(bus.tx_wr_en), 0);
    chk({pfx, "_tx_data"},    32'(bus.tx_data), 0);
    chk({pfx, "_ub_we"},      32'(bus.ub_we), 0);
    chk({pfx, "_ub_re"},      32'(bus.ub_re), 0);
    chk({pfx, "_fifo_en"},    32'(bus.ub_fifo_en), 0);
    chk({pfx, "_compute_en"}, 32'(bus.ub_compute_en), 0);
    chk({pfx, "_section"},    32'(bus.ub_section), 0);
    chk({pfx, "_address"},    32'(bus.ub_address), 0);
    chk({pfx, "_fifo_in"},    32'(bus.ub_fifo_in), 0);
  endtask

  task automatic do_cmd(input logic d, input int base, input int cnt, input bit poke);
    int n;
    bit seen;
    int d0;
    d0 = done_cnt;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.dir = d; bus.base_addr = base[9:0]; bus.word_count = cnt[10:0];
    @(posedge clk); #2;
    bus.start = 1'b0; bus.dir = 1'($urandom);
    bus.base_addr = 10'($urandom); bus.word_count = 11'($urandom);
    @(negedge clk);
    chk("busy_after_start", 32'(bus.busy), 1);
    seen = bus.done;
    n = 0;
    while (!seen && n < 80 + cnt * 120) begin
      bus.start = poke && (n == 2);
      @(negedge clk);
      n++;
      seen = bus.done;
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(seen), 1);
    if (cnt == 0) chk("zero_done_latency", n, 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 0);
    chk("busy_after_done", 32'(bus.busy), 0);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic check_load(input int base, input int cnt, input bit poke);
    int p0, w0, r0, s0, v0, mism;
    @(posedge clk); #2;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < cnt; i++) ref_mem[(base + i) % 1024] = {stim_q[2*i+1], stim_q[2*i]};
    foreach (stim_q[i]) rx_q.push_back(stim_q[i]);
    p0 = pop_cnt; w0 = we_cnt; r0 = re_cnt; s0 = push_cnt; v0 = viol;
    do_cmd(1'b0, base, cnt, poke);
    chk("ld_pops",   pop_cnt - p0, 2 * cnt);
    chk("ld_writes", we_cnt - w0, 2 * cnt);
    chk("ld_reads",  re_cnt - r0, 0);
    chk("ld_pushes", push_cnt - s0, 0);
    chk("ld_protocol", viol - v0, 0);
    for (int i = 0; i < cnt; i++)
      chk("ld_word", 32'(mem[(base + i) % 1024]), 32'(ref_mem[(base + i) % 1024]));
    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("ld_image", mism, 0);
  endtask

  task automatic check_store(input int base, input int cnt, input bit poke);
    int p0, w0, r0, s0, v0;
    logic [15:0] w;
    @(posedge clk); #2;
    exp_tx.delete();
    for (int i = 0; i < cnt; i++) begin
      w = mem[(base + i) % 1024];
      exp_tx.push_back(w[7:0]);
      exp_tx.push_back(w[15:8]);
    end
    tx_q.delete();
    p0 = pop_cnt; w0 = we_cnt; r0 = re_cnt; s0 = push_cnt; v0 = viol;
    do_cmd(1'b1, base, cnt, poke);
    chk("st_pushes", push_cnt - s0, 2 * cnt);
    chk("st_reads",  re_cnt - r0, 2 * cnt);
    chk("st_writes", we_cnt - w0, 0);
    chk("st_pops",   pop_cnt - p0, 0);
    chk("st_protocol", viol - v0, 0);
    foreach (exp_tx[i]) chk("st_byte", tx_at(i), {24'h0, exp_tx[i]});
  endtask

  initial begin : main
    int n, b, c;
    logic d;
    stall_at = -1; stall_left = 0; rx_toggle = 0; rand_gaps = 0;
    pop_cnt = 0; we_cnt = 0; re_cnt = 0; push_cnt = 0; done_cnt = 0; viol = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.dir = 1'b0; bus.base_addr = '0; bus.word_count = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("idle");

    stim_q.delete();
    stim_q.push_back(8'hAA); stim_q.push_back(8'hBB);
    stim_q.push_back(8'hCC); stim_q.push_back(8'hDD);
    check_load(16, 2, 1'b0);
    chk("load_w010", 32'(mem[16]), 32'h0000BBAA);
    chk("load_w011", 32'(mem[17]), 32'h0000DDCC);

    @(posedge clk); #2;
    mem[1023] = 16'h1234; mem[0] = 16'h5678;
    check_store(1023, 2, 1'b0);
    chk("wrap_b0", tx_at(0), 32'h34);
    chk("wrap_b1", tx_at(1), 32'h12);
    chk("wrap_b2", tx_at(2), 32'h78);
    chk("wrap_b3", tx_at(3), 32'h56);

    @(posedge clk); #2;
    mem[256] = 16'($urandom); mem[257] = 16'($urandom);
    stall_at = push_cnt + 1; stall_left = 5;
    check_store(256, 2, 1'b0);
    chk("stall_consumed", stall_left, 0);

    rx_toggle = 1;
    stim_q.delete();
    for (int k = 0; k < 6; k++) stim_q.push_back(8'($urandom));
    check_load(512, 3, 1'b0);
    rx_toggle = 0;

    stim_q.delete();
    check_load(100, 0, 1'b0);
    check_store(100, 0, 1'b0);

    // abort a load after its first byte, then rerun cleanly
    @(posedge clk); #2;
    for (int k = 0; k < 4; k++) rx_q.push_back(8'($urandom));
    b = done_cnt;
    bus.start = 1'b1; bus.dir = 1'b0; bus.base_addr = 10'h040; bus.word_count = 11'd2;
    c = pop_cnt;
    @(posedge clk); #2 bus.start = 1'b0;
    n = 0;
    while (pop_cnt == c && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_pop_seen", pop_cnt - c, 1);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("abort");
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_cnt - b, 0);
    chk("abort_idle", 32'(bus.busy), 0);
    @(posedge clk); #2 rx_q.delete();
    stim_q.delete();
    for (int k = 0; k < 4; k++) stim_q.push_back(8'($urandom));
    check_load(64, 2, 1'b0);

    rand_gaps = 1;
    for (int it = 0; it < 24; it++) begin
      d = 1'($urandom_range(0, 1));
      c = $urandom_range(1, 5);
      b = (it % 4 == 0) ? $urandom_range(1019, 1023) : $urandom_range(0, 1023);
      if (!d) begin
        stim_q.delete();
        for (int k = 0; k < 2 * c; k++) stim_q.push_back(8'($urandom));
        check_load(b, c, it[0]);
      end else begin
        @(posedge clk); #2;
        for (int k = 0; k < c; k++) mem[(b + k) % 1024] = 16'($urandom);
        check_store(b, c, it[0]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end
endmodule
